// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: the arbiter state
// encoding and the ASCII control characters used by the message sequencers.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RELEASE
    } arb_state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: starting just after last_owner and wrapping,
// return the first requester that is asking for the port.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [IW-1:0] w_cand;

    // Walk the candidates from the farthest offset down to the nearest one so
    // that the closest requester after last_owner is the last to overwrite.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_cand = IW'((int'(last_owner) + off) % NREQ);
            if (req[w_cand]) begin
                winner = w_cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ message sequencers. A requester owns
// the port for a whole message; ownership rotates round-robin and a watchdog
// takes the port back from an owner that stops loading bytes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535,
    parameter int CW      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         done,
    input  logic [NREQ-1:0]         ldtxdata_in,
    input  logic [NREQ*8-1:0]       txdata_in,
    input  logic                    txempty,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         txempty_out,
    output logic [7:0]              txdata,
    output logic                    ldtxdata,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    timeout_err
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_lastOwner;
    logic            r_busy;
    logic            r_timeoutErr;
    logic [CW-1:0]   r_wdog;

    logic [IW-1:0]   w_winner;
    logic            w_valid;
    logic            w_granted;
    logic            w_ownerLd;
    logic            w_expire;
    logic            w_release;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req        (req),
        .last_owner (r_lastOwner),
        .winner     (w_winner),
        .valid      (w_valid)
    );

    assign w_granted = |r_gnt;
    assign w_ownerLd = ldtxdata_in[r_owner];
    assign w_expire  = (r_wdog == CW'(TIMEOUT - 1)) && !w_ownerLd;
    assign w_release = done[r_owner] || !req[r_owner] || w_expire;

    assign gnt         = r_gnt;
    assign owner       = r_owner;
    assign busy        = r_busy;
    assign timeout_err = r_timeoutErr;

    assign txdata      = w_granted ? txdata_in[{r_owner, 3'b000} +: 8] : 8'h00;
    assign ldtxdata    = w_granted && w_ownerLd;
    assign txempty_out = r_gnt & {NREQ{txempty}};

    // Arbiter FSM: grant in IDLE, watch the owner in GRANT, and in RELEASE hold
    // off the next grant until the last byte has drained from the UART.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_lastOwner  <= IW'(NREQ - 1);
            r_busy       <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_wdog       <= '0;
        end else begin
            r_timeoutErr <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_gnt   <= NREQ'(1) << w_winner;
                        r_owner <= w_winner;
                        r_busy  <= 1'b1;
                        r_wdog  <= '0;
                        r_state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_release) begin
                        r_gnt        <= '0;
                        r_lastOwner  <= r_owner;
                        r_timeoutErr <= w_expire;
                        r_wdog       <= '0;
                        r_state      <= ARB_RELEASE;
                    end else if (w_ownerLd) begin
                        r_wdog <= '0;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ARB_RELEASE: begin
                    if (txempty) begin
                        r_busy  <= 1'b0;
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed message scenarios plus a port-ownership
// model that predicts every output on every cycle.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  done = '0;
    logic [3:0]  ldtxdata_in = '0;
    logic [31:0] txdata_in = '0;
    logic        txempty = 1'b1;
    logic [3:0]  gnt;
    logic [3:0]  txempty_out;
    logic [7:0]  txdata;
    logic        ldtxdata;
    logic        busy;
    logic [1:0]  owner;
    logic        timeout_err;

    int nChecks = 0;
    int nPass   = 0;

    // Model of who holds the port and what it has been doing
    bit         mOwned  = 1'b0;
    bit         mDrain  = 1'b0;
    bit         mTo     = 1'b0;
    int         mOwner  = 0;
    int         mLast   = NREQ - 1;
    int         mQuiet  = 0;
    logic [3:0] prevGnt = '0;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .CW      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .ldtxdata_in (ldtxdata_in),
        .txdata_in   (txdata_in),
        .txempty     (txempty),
        .gnt         (gnt),
        .txempty_out (txempty_out),
        .txdata      (txdata),
        .ldtxdata    (ldtxdata),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    // One cycle: inputs change just after the rising edge, outputs are
    // examined just after the falling edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d,
                                 input logic [3:0] l, input logic [31:0] data,
                                 input logic te);
        @(posedge clk);
        #1;
        req = r; done = d; ldtxdata_in = l; txdata_in = data; txempty = te;
        @(negedge clk);
        #1;
    endtask

    task automatic waitGrant(input logic [3:0] r, output int idx);
        idx = -1;
        for (int k = 0; k < 20 && idx < 0; k++) begin
            applyStimulus(r, 4'b0, 4'b0, 32'h0, 1'b1);
            for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
        end
        checkOutput("grant_within_bound", 32'(idx >= 0), 32'd1);
    endtask

    task automatic settle();
        for (int k = 0; k < 20 && busy; k++) applyStimulus(4'b0, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("settle_busy", 32'(busy), 32'd0);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = '0; done = '0; ldtxdata_in = '0; txdata_in = '0; txempty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison against the ownership model, then advance the model
    // with the inputs the next rising edge will see.
    initial begin
        logic [3:0] expGnt;
        logic [7:0] expData;
        bit expire;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mOwned = 1'b0; mDrain = 1'b0; mTo = 1'b0;
                mOwner = 0; mLast = NREQ - 1; mQuiet = 0;
            end
            expGnt  = mOwned ? (4'b0001 << mOwner) : 4'b0000;
            expData = mOwned ? txdata_in[8*mOwner +: 8] : 8'h00;
            checkOutput("gnt", 32'(gnt), 32'(expGnt));
            checkOutput("busy", 32'(busy), 32'(mOwned || mDrain));
            checkOutput("owner", 32'(owner), 32'(mOwner));
            checkOutput("timeout_err", 32'(timeout_err), 32'(mTo));
            checkOutput("txdata", 32'(txdata), 32'(expData));
            checkOutput("ldtxdata", 32'(ldtxdata), 32'(mOwned && ldtxdata_in[mOwner]));
            checkOutput("txempty_out", 32'(txempty_out), 32'(mOwned ? (txempty ? expGnt : 4'b0) : 4'b0));
            checkOutput("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            checkOutput("grant_gap", 32'(gnt != 0 && prevGnt != 0 && gnt != prevGnt), 32'd0);
            prevGnt = gnt;
            if (rst_n) begin
                mTo = 1'b0;
                if (mOwned) begin
                    if (ldtxdata_in[mOwner]) mQuiet = 0;
                    else mQuiet++;
                    expire = (mQuiet >= TIMEOUT);
                    if (done[mOwner] || !req[mOwner] || expire) begin
                        mOwned = 1'b0; mDrain = 1'b1; mLast = mOwner; mTo = expire;
                    end
                end else if (mDrain) begin
                    if (txempty) mDrain = 1'b0;
                end else begin
                    for (int off = NREQ; off >= 1; off--) begin
                        if (req[(mLast + off) % NREQ]) begin
                            mOwner = (mLast + off) % NREQ;
                            mOwned = 1'b1;
                        end
                    end
                    if (mOwned) mQuiet = 0;
                end
            end
        end
    end

    // Hard stop in case a scenario wedges
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    // Directed scenarios
    initial begin
        int idx;
        int order[5];
        int expOrder[5] = '{0, 1, 2, 3, 0};
        logic [31:0] data;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester: one-cycle grant latency
        applyStimulus(4'b0001, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t1_gnt_before", 32'(gnt), 32'h0);
        applyStimulus(4'b0001, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t1_gnt", 32'(gnt), 32'h1);
        checkOutput("t1_busy", 32'(busy), 32'h1);
        checkOutput("t1_owner", 32'(owner), 32'h0);

        // Owner byte passes straight through
        applyStimulus(4'b0001, 4'b0, 4'b0001, 32'h0000_0064, 1'b0);
        checkOutput("t2_txdata", 32'(txdata), 32'h64);
        checkOutput("t2_ldtxdata", 32'(ldtxdata), 32'h1);
        checkOutput("t2_txempty_out_lo", 32'(txempty_out), 32'h0);
        applyStimulus(4'b0001, 4'b0, 4'b0, 32'h0000_0064, 1'b1);
        checkOutput("t2_txempty_out_hi", 32'(txempty_out), 32'h1);
        checkOutput("t2_ldtxdata_idle", 32'(ldtxdata), 32'h0);

        // Non-owner strobes are ignored; owner dropping req releases
        applyStimulus(4'b0011, 4'b0010, 4'b0010, 32'h0000_AB00, 1'b1);
        checkOutput("t5_nonowner_ld", 32'(ldtxdata), 32'h0);
        checkOutput("t5_nonowner_data", 32'(txdata), 32'h0);
        applyStimulus(4'b0011, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t5_no_release", 32'(gnt), 32'h1);
        applyStimulus(4'b0010, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t5_drop_cycle", 32'(gnt), 32'h1);
        applyStimulus(4'b0000, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t5_released", 32'(gnt), 32'h0);
        checkOutput("t5_busy_release", 32'(busy), 32'h1);
        applyStimulus(4'b0000, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t5_busy_idle", 32'(busy), 32'h0);

        // Four competing requesters rotate 0,1,2,3,0
        resetDut();
        for (int m = 0; m < 5; m++) begin
            waitGrant(4'b1111, idx);
            order[m] = idx;
            if (idx < 0) idx = 0;
            data = {24'h0, 8'h41 + 8'(m)} << (8 * idx);
            applyStimulus(4'b1111, 4'b0001 << idx, 4'b0001 << idx, data, 1'b1);
            checkOutput("t3_ldtxdata", 32'(ldtxdata), 32'h1);
            checkOutput("t3_txdata", 32'(txdata), 32'h41 + 32'(m));
            applyStimulus(4'b1111, 4'b0, 4'b0, 32'h0, 1'b0);
            checkOutput("t3_gap_gnt", 32'(gnt), 32'h0);
            checkOutput("t3_gap_busy", 32'(busy), 32'h1);
            applyStimulus(4'b1111, 4'b0, 4'b0, 32'h0, 1'b0);
            checkOutput("t3_drain_hold", 32'(gnt), 32'h0);
        end
        for (int m = 0; m < 5; m++) checkOutput("t3_order", 32'(order[m]), 32'(expOrder[m]));
        settle();

        // Stalled owner 2 is revoked after TIMEOUT idle cycles; 3 is next
        waitGrant(4'b0100, idx);
        checkOutput("t4_owner2", 32'(idx), 32'd2);
        for (int k = 1; k < TIMEOUT; k++) begin
            applyStimulus(4'b1100, 4'b0, 4'b0, 32'h0, 1'b1);
            checkOutput("t4_no_early_timeout", 32'(timeout_err), 32'h0);
        end
        applyStimulus(4'b1100, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t4_timeout_pulse", 32'(timeout_err), 32'h1);
        checkOutput("t4_gnt_revoked", 32'(gnt), 32'h0);
        applyStimulus(4'b1100, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t4_timeout_once", 32'(timeout_err), 32'h0);
        waitGrant(4'b1100, idx);
        checkOutput("t4_next_owner3", 32'(idx), 32'd3);
        settle();

        // Asynchronous reset in the middle of a message
        waitGrant(4'b0001, idx);
        checkOutput("t6_owner0", 32'(idx), 32'd0);
        applyStimulus(4'b0001, 4'b0, 4'b0001, 32'h0000_0055, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_gnt", 32'(gnt), 32'h0);
        checkOutput("t6_rst_busy", 32'(busy), 32'h0);
        checkOutput("t6_rst_txdata", 32'(txdata), 32'h0);
        checkOutput("t6_rst_ldtxdata", 32'(ldtxdata), 32'h0);
        checkOutput("t6_rst_txempty_out", 32'(txempty_out), 32'h0);
        checkOutput("t6_rst_owner", 32'(owner), 32'h0);
        checkOutput("t6_rst_timeout", 32'(timeout_err), 32'h0);
        req = '0; done = '0; ldtxdata_in = '0; txdata_in = '0; txempty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b0100, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t6_gnt_before", 32'(gnt), 32'h0);
        applyStimulus(4'b0100, 4'b0, 4'b0, 32'h0, 1'b1);
        checkOutput("t6_gnt", 32'(gnt), 32'h4);
        checkOutput("t6_owner", 32'(owner), 32'h2);
        settle();

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
